uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive stage that re-phases the baud generator on each start edge
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_start,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, ARM0, ARM1, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 par_err;
  logic                 par_calc;
  logic                 break_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall     = ~rx_sync & rx_prev;
  // Odd mode flips the sense: an even count of ones including parity is the error.
  assign par_calc = (^shift) ^ rx_sync ^ PARITY_ODD;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_start = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fall && !break_hold) state_next = ARM0;
      end
      // Ticks are ignored while arming: a generator already at its max count
      // drops the start request and emits one stale tick.
      ARM0: begin
        baud_start = 1'b1;
        state_next = ARM1;
      end
      ARM1: begin
        baud_start = 1'b1;
        state_next = START;
      end
      START: begin
        if (baud_tick) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (baud_tick && bit_cnt == LAST_BIT) state_next = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (baud_tick) state_next = STOP;
      end
      STOP: begin
        if (baud_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift         <= '0;
      bit_cnt       <= '0;
      par_err       <= 1'b0;
      break_hold    <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (rx_sync) break_hold <= 1'b0;
      case (state)
        START: begin
          if (baud_tick && !rx_sync) bit_cnt <= '0;
        end
        DATA: begin
          if (baud_tick) begin
            shift   <= {rx_sync, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (baud_tick) par_err <= par_calc;
        end
        STOP: begin
          if (baud_tick) begin
            data          <= shift;
            framing_error <= ~rx_sync;
            parity_error  <= PARITY_EN & par_err;
            data_valid    <= 1'b1;
            // A low stop bit is a break: wait for the line to recover before re-arming.
            if (!rx_sync) break_hold <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx paired with a 5-cycle baud generator model
module tb_uart_rx;

  localparam logic [2:0] GEN_MAX = 3'd4;

  logic       clock;
  logic       reset;
  logic       rx_a;
  logic       rx_p;
  logic       tick;
  logic [2:0] gen_cnt;

  logic       start_a, dv_a, pe_a, fe_a, busy_a;
  logic [7:0] data_a;
  logic       start_p, dv_p, pe_p, fe_p, busy_p;
  logic [7:0] data_p;

  int vectors     = 0;
  int miscompares = 0;

  int dv_a_cnt = 0, dv_p_cnt = 0, start_a_cycles = 0, arm_ticks = 0, busy_a_cycles = 0;
  logic [9:0] cap_a [0:15];
  logic [9:0] cap_p [0:15];

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_a), .baud_tick(tick), .baud_start(start_a),
    .data(data_a), .data_valid(dv_a), .parity_error(pe_a), .framing_error(fe_a), .busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clock(clock), .reset(reset), .rx(rx_p), .baud_tick(tick), .baud_start(start_p),
    .data(data_p), .data_valid(dv_p), .parity_error(pe_p), .framing_error(fe_p), .busy(busy_p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Generator model: start reloads to max so the first tick after arming lands
  // inside the start bit despite the receiver's synchronizer and arm latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gen_cnt <= '0;
      tick    <= 1'b0;
    end else if (gen_cnt == GEN_MAX) begin
      gen_cnt <= '0;
      tick    <= 1'b1;
    end else if (start_a || start_p) begin
      gen_cnt <= GEN_MAX;
      tick    <= 1'b0;
    end else begin
      gen_cnt <= gen_cnt + 3'd1;
      tick    <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (dv_a) begin
      cap_a[dv_a_cnt[3:0]] = {pe_a, fe_a, data_a};
      dv_a_cnt = dv_a_cnt + 1;
    end
    if (dv_p) begin
      cap_p[dv_p_cnt[3:0]] = {pe_p, fe_p, data_p};
      dv_p_cnt = dv_p_cnt + 1;
    end
    if (start_a) start_a_cycles = start_a_cycles + 1;
    if (start_a && tick) arm_ticks = arm_ticks + 1;
    if (busy_a) busy_a_cycles = busy_a_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 time units");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic align(input logic [2:0] phase);
    for (int i = 0; i < 12 && gen_cnt != phase; i++) @(negedge clock);
  endtask

  task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_p = bits[i];
      else     rx_a = bits[i];
      repeat (5) @(negedge clock);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] b, input logic stop);
    return {6'b0, stop, b, 1'b0};
  endfunction

  function automatic logic [15:0] f8p1(input logic [7:0] b, input logic par, input logic stop);
    return {5'b0, stop, par, b, 1'b0};
  endfunction

  int d0, s0, b0, t0;

  initial begin
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_p  = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_data", 32'(data_a), 32'h0);
    check("rst_valid", 32'(dv_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_start", 32'(start_a), 32'h0);
    check("rst_fe", 32'(fe_a), 32'h0);
    check("rst_pe", 32'(pe_a), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    d0 = dv_a_cnt; s0 = start_a_cycles; t0 = arm_ticks;
    align(3'd0);
    send_bits(1'b0, f8n1(8'hA5, 1'b1), 10);
    repeat (5) @(negedge clock);
    check("a5_start_cycles", 32'(start_a_cycles - s0), 32'd2);
    check("a5_arm_ticks", 32'(arm_ticks - t0), 32'd0);
    check("a5_valid_count", 32'(dv_a_cnt - d0), 32'd1);
    check("a5_capture", 32'(cap_a[d0[3:0]]), 32'h0A5);
    check("a5_busy_after", 32'(busy_a), 32'h0);

    d0 = dv_a_cnt; b0 = busy_a_cycles;
    align(3'd0);
    rx_a = 1'b0;
    repeat (2) @(negedge clock);
    rx_a = 1'b1;
    repeat (15) @(negedge clock);
    check("glitch_no_valid", 32'(dv_a_cnt - d0), 32'd0);
    check("glitch_busy_bounded", 32'((busy_a_cycles - b0) > 0 && (busy_a_cycles - b0) <= 7), 32'd1);
    check("glitch_data_held", 32'(data_a), 32'hA5);
    check("glitch_idle", 32'(busy_a), 32'h0);

    d0 = dv_a_cnt;
    align(3'd0);
    send_bits(1'b0, f8n1(8'h3C, 1'b0), 10);
    repeat (5) @(negedge clock);
    check("brk_valid_count", 32'(dv_a_cnt - d0), 32'd1);
    check("brk_capture", 32'(cap_a[d0[3:0]]), 32'h13C);
    b0 = busy_a_cycles;
    repeat (20) @(negedge clock);
    check("brk_no_restart", 32'(busy_a_cycles - b0), 32'd0);
    check("brk_no_extra_valid", 32'(dv_a_cnt - d0), 32'd1);
    rx_a = 1'b1;
    repeat (10) @(negedge clock);

    d0 = dv_a_cnt; t0 = arm_ticks;
    align(3'd1);
    send_bits(1'b0, f8n1(8'h55, 1'b1), 10);
    repeat (5) @(negedge clock);
    check("stale_tick_seen", 32'(arm_ticks - t0), 32'd1);
    check("stale_valid_count", 32'(dv_a_cnt - d0), 32'd1);
    check("stale_capture", 32'(cap_a[d0[3:0]]), 32'h055);
    check("stale_fe_cleared", 32'(fe_a), 32'h0);

    d0 = dv_p_cnt;
    align(3'd0);
    send_bits(1'b1, f8p1(8'h07, 1'b1, 1'b1), 11);
    repeat (5) @(negedge clock);
    check("par_ok_count", 32'(dv_p_cnt - d0), 32'd1);
    check("par_ok_capture", 32'(cap_p[d0[3:0]]), 32'h007);
    d0 = dv_p_cnt;
    align(3'd0);
    send_bits(1'b1, f8p1(8'h07, 1'b0, 1'b1), 11);
    repeat (5) @(negedge clock);
    check("par_bad_count", 32'(dv_p_cnt - d0), 32'd1);
    check("par_bad_capture", 32'(cap_p[d0[3:0]]), 32'h207);
    check("par_bad_flag_held", 32'(pe_p), 32'h1);

    d0 = dv_a_cnt;
    align(3'd0);
    send_bits(1'b0, f8n1(8'h11, 1'b1), 10);
    send_bits(1'b0, f8n1(8'h22, 1'b1), 10);
    repeat (5) @(negedge clock);
    check("b2b_count", 32'(dv_a_cnt - d0), 32'd2);
    check("b2b_first", 32'(cap_a[d0[3:0]]), 32'h011);
    check("b2b_second", 32'(cap_a[4'(d0 + 1)]), 32'h022);

    d0 = dv_a_cnt;
    align(3'd0);
    send_bits(1'b0, f8n1(8'h81, 1'b1), 5);
    rx_a = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_busy", 32'(busy_a), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy_a), 32'h0);
    check("rst_mid_data", 32'(data_a), 32'h0);
    check("rst_mid_valid", 32'(dv_a), 32'h0);
    check("rst_mid_start", 32'(start_a), 32'h0);
    rx_a = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_no_valid", 32'(dv_a_cnt - d0), 32'd0);

    d0 = dv_a_cnt;
    align(3'd0);
    send_bits(1'b0, f8n1(8'h81, 1'b1), 10);
    repeat (5) @(negedge clock);
    check("post_rst_count", 32'(dv_a_cnt - d0), 32'd1);
    check("post_rst_capture", 32'(cap_a[d0[3:0]]), 32'h081);
    check("post_rst_idle", 32'(busy_a), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
